// File: rtl/nand_flash_pkg.sv
// Shared op codes, FSM states and default geometry for the NAND flash controller.
package nand_flash_pkg;

   localparam int unsigned DEF_BLOCKS       = 4;
   localparam int unsigned DEF_PAGES        = 4;
   localparam int unsigned DEF_PAGE_SIZE    = 16;
   localparam int unsigned DEF_BUSY_TIMEOUT = 32;
   localparam int unsigned BYTE_W           = 8;

   typedef enum logic [1:0] {
      OP_IDLE    = 2'b00,
      OP_ERASE   = 2'b01,
      OP_PROGRAM = 2'b10,
      OP_READ    = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      ERASE,
      PROG,
      READ,
      WAITB,
      VRFY,
      DONE
   } state_t;

endpackage

// File: rtl/nand_page_buf.sv
// One-page byte buffer (1 write port, 1 async read port) holding PROGRAM data for read-back.
// Present only when NAND_CTRL_VERIFY_EN is defined.
`ifdef NAND_CTRL_VERIFY_EN
module nand_page_buf
   import nand_flash_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_PAGE_SIZE,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [BYTE_W-1:0] rdata
);

   logic [BYTE_W-1:0] mem [DEPTH];

   // Capture each accepted program byte at its page offset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`endif

// File: rtl/nand_flash_ctrl.sv
// Host-side NAND flash controller: one ERASE/PROGRAM/READ page request at a time.
// Optional NAND_CTRL_VERIFY_EN: buffers PROGRAM data and re-reads the page to check it.
module nand_flash_ctrl
   import nand_flash_pkg::*;
#(
   parameter int unsigned BLOCKS       = DEF_BLOCKS,
   parameter int unsigned PAGES        = DEF_PAGES,
   parameter int unsigned PAGE_SIZE    = DEF_PAGE_SIZE,
   parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_blk,
   input  logic [7:0] req_page,
   input  logic       wdata_valid,
   output logic       wdata_ready,
   input  logic [7:0] wdata,
   output logic       rdata_valid,
   output logic [7:0] rdata,
   output logic       done,
   output logic       err,
   output logic [1:0] f_cmd,
   output logic [7:0] f_blk,
   output logic [7:0] f_page,
   output logic [7:0] f_din,
   output logic       f_wr_en,
   input  logic [7:0] f_dout,
   input  logic       f_busy
);

   localparam int unsigned BCNT_W = $clog2(PAGE_SIZE) + 1;
   localparam int unsigned AW     = $clog2(PAGE_SIZE);
   localparam int unsigned TCNT_W = $clog2(BUSY_TIMEOUT + 1);

   state_t            state;
   logic [BCNT_W-1:0] bcnt;
   logic [TCNT_W-1:0] tcnt;
   logic              legal;
   logic              wr_hs;

   assign req_ready   = (state == IDLE);
   assign wdata_ready = (state == PROG) && (bcnt < BCNT_W'(PAGE_SIZE));
   assign wr_hs       = wdata_valid && wdata_ready;
   assign rdata       = f_dout;
   assign legal       = (req_op != OP_IDLE) && (req_blk < 8'(BLOCKS)) && (req_page < 8'(PAGES));

`ifdef NAND_CTRL_VERIFY_EN
   logic              is_prog;
   logic              vfail;
   logic [AW-1:0]     buf_raddr;
   logic [BYTE_W-1:0] buf_rdata;

   // Read-back compares byte bcnt-1, which the device presents one cycle after its read cycle.
   assign buf_raddr = AW'(bcnt - BCNT_W'(1));

   nand_page_buf #(.DEPTH(PAGE_SIZE), .AW(AW)) u_page_buf (
      .clk   (clk),
      .we    (wr_hs),
      .waddr (AW'(bcnt)),
      .wdata (wdata),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );
`endif

   // Request sequencing FSM with registered flash pins and status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         f_cmd       <= OP_IDLE;
         f_blk       <= '0;
         f_page      <= '0;
         f_din       <= '0;
         f_wr_en     <= 1'b0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         bcnt        <= '0;
         tcnt        <= '0;
`ifdef NAND_CTRL_VERIFY_EN
         is_prog     <= 1'b0;
         vfail       <= 1'b0;
`endif
      end else begin
         f_wr_en     <= 1'b0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (!legal) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     f_blk  <= req_blk;
                     f_page <= req_page;
                     f_cmd  <= req_op;
                     bcnt   <= '0;
`ifdef NAND_CTRL_VERIFY_EN
                     is_prog <= (req_op == OP_PROGRAM);
`endif
                     case (req_op)
                        OP_ERASE:   state <= ERASE;
                        OP_PROGRAM: state <= PROG;
                        default:    state <= READ;
                     endcase
                  end
               end
            end
            ERASE: begin
               f_cmd <= OP_IDLE;
               tcnt  <= '0;
               state <= WAITB;
            end
            PROG: begin
               if (wr_hs) begin
                  f_wr_en <= 1'b1;
                  f_din   <= wdata;
                  bcnt    <= bcnt + BCNT_W'(1);
               end
               // The last strobe is on the pins this cycle with the command still asserted.
               if (bcnt == BCNT_W'(PAGE_SIZE)) begin
                  f_cmd <= OP_IDLE;
                  tcnt  <= '0;
                  state <= WAITB;
               end
            end
            READ: begin
               rdata_valid <= 1'b1;
               bcnt        <= bcnt + BCNT_W'(1);
               if (bcnt == BCNT_W'(PAGE_SIZE - 1)) begin
                  f_cmd <= OP_IDLE;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            WAITB: begin
               if (!f_busy) begin
                  state <= DONE;
                  done  <= 1'b1;
`ifdef NAND_CTRL_VERIFY_EN
                  if (is_prog) begin
                     state <= VRFY;
                     done  <= 1'b0;
                     f_cmd <= OP_READ;
                     bcnt  <= '0;
                     vfail <= 1'b0;
                  end
`endif
               end else if (tcnt == TCNT_W'(BUSY_TIMEOUT - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end
`ifdef NAND_CTRL_VERIFY_EN
            VRFY: begin
               bcnt <= bcnt + BCNT_W'(1);
               if (bcnt == BCNT_W'(PAGE_SIZE - 1)) begin
                  f_cmd <= OP_IDLE;
               end
               if ((bcnt != '0) && (f_dout != buf_rdata)) begin
                  vfail <= 1'b1;
               end
               if (bcnt == BCNT_W'(PAGE_SIZE)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= vfail || (f_dout != buf_rdata);
               end
            end
`endif
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               f_cmd <= OP_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nand_flash_ctrl.sv
// Bench for nand_flash_ctrl: pin-level flash model plus a page-level reference of flash contents.
module tb_nand_flash_ctrl;
   import nand_flash_pkg::*;

   localparam int NB = 4;
   localparam int NP = 4;
   localparam int PS = 16;
   localparam int BT = 32;
   localparam int NV = 10;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_blk;
   logic [7:0] req_page;
   logic       wdata_valid;
   logic       wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid;
   logic [7:0] rdata;
   logic       done;
   logic       err;
   logic [1:0] f_cmd;
   logic [7:0] f_blk;
   logic [7:0] f_page;
   logic [7:0] f_din;
   logic       f_wr_en;
   logic [7:0] f_dout;
   logic       f_busy;

   nand_flash_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_blk(req_blk), .req_page(req_page),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata),
      .done(done), .err(err),
      .f_cmd(f_cmd), .f_blk(f_blk), .f_page(f_page), .f_din(f_din),
      .f_wr_en(f_wr_en), .f_dout(f_dout), .f_busy(f_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- flash device model ----------------
   logic [7:0] fmem [NB*NP*PS];
   logic [3:0] fptr;
   bit         model_ready;
   int         busy_cnt;
   int         busy_len;
   logic       force_busy;
   logic       flip_arm;

   function automatic int fidx(input logic [3:0] k);
      return int'({f_blk[1:0], f_page[1:0], k});
   endfunction

   // Registered device: erase, byte program, byte read with 1-cycle latency, busy after erase/program.
   always @(posedge clk) begin
      if (!model_ready) begin
         for (int i = 0; i < NB*NP*PS; i++) fmem[i] <= 8'(i*7 + 3);
         fptr        <= 4'd0;
         f_dout      <= 8'h00;
         model_ready <= 1'b1;
      end else begin
         if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
         case (f_cmd)
            2'b00: fptr <= 4'd0;
            2'b01: begin
               for (int i = 0; i < PS; i++) fmem[fidx(4'(i))] <= 8'hFF;
               busy_cnt <= busy_len;
            end
            2'b10: if (f_wr_en) begin
               fmem[fidx(fptr)] <= f_din;
               fptr <= fptr + 4'd1;
               if (fptr == 4'd15) busy_cnt <= busy_len;
            end
            default: begin
               f_dout <= fmem[fidx(fptr)] ^ ((flip_arm && fptr == 4'd7) ? 8'h01 : 8'h00);
               fptr   <= fptr + 4'd1;
            end
         endcase
      end
   end

   assign f_busy = force_busy || (busy_cnt != 0);

   // ---------------- reference and checking ----------------
   logic [7:0] ref_pg [NB][NP][PS];
   logic [7:0] wbuf [PS];
   int n_checks;
   int n_fail;
   int gap_pct;

   logic [7:0] got_wr [$];
   logic [7:0] got_rd [$];
   int   t_done, t_c01, t_c11, t_rv_first, t_rv_last;
   int   n_c01, n_c10, n_c11, n_rv;
   logic got_done, got_err, ready_at_done;

   typedef struct {
      logic [1:0] op;
      logic [7:0] blk;
      logic [7:0] page;
      int         pat;
      logic       illegal;
   } vec_t;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_f_cmd"}, 32'(f_cmd), 0);
      chk({tag, "_f_wr_en"}, 32'(f_wr_en), 0);
      chk({tag, "_f_din"}, 32'(f_din), 0);
      chk({tag, "_f_blk"}, 32'(f_blk), 0);
      chk({tag, "_f_page"}, 32'(f_page), 0);
      chk({tag, "_rdata_valid"}, 32'(rdata_valid), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_req_ready"}, 32'(req_ready), 1);
      chk({tag, "_wdata_ready"}, 32'(wdata_ready), 0);
   endtask

   // Issue one request and record everything seen on the pins until done.
   task automatic run_op(input logic [1:0] op, input logic [7:0] blk, input logic [7:0] page);
      int idx;
      got_wr.delete(); got_rd.delete();
      t_done = -1; t_c01 = -1; t_c11 = -1; t_rv_first = -1; t_rv_last = -1;
      n_c01 = 0; n_c10 = 0; n_c11 = 0; n_rv = 0;
      got_done = 1'b0; got_err = 1'b0; ready_at_done = 1'b0;
      idx = 0;
      @(posedge clk); #1;
      chk("req_ready_idle", 32'(req_ready), 1);
      req_valid = 1'b1; req_op = op; req_blk = blk; req_page = page;
      for (int t = 1; t <= 400 && !got_done; t++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (f_cmd == 2'b01) begin n_c01++; if (t_c01 < 0) t_c01 = t; end
         if (f_cmd == 2'b10) n_c10++;
         if (f_cmd == 2'b11) begin n_c11++; if (t_c11 < 0) t_c11 = t; end
         if (f_wr_en) got_wr.push_back(f_din);
         if (rdata_valid) begin
            got_rd.push_back(rdata);
            n_rv++;
            if (t_rv_first < 0) t_rv_first = t;
            t_rv_last = t;
         end
         if (done) begin
            got_done = 1'b1; got_err = err; t_done = t; ready_at_done = req_ready;
         end
         wdata_valid = (op == OP_PROGRAM) && (idx < PS) && ($urandom_range(99) >= 32'(gap_pct));
         wdata = (idx < PS) ? wbuf[idx] : 8'h00;
         if (wdata_valid && wdata_ready) idx++;
      end
      wdata_valid = 1'b0;
      chk("done_seen", 32'(got_done), 1);
      if (got_done) begin
         @(posedge clk); #1;
         chk("ready_after_done", 32'(req_ready), 1);
      end
   endtask

   // Compare the recorded activity against the page-level expectations and update the reference.
   task automatic check_op(input logic [1:0] op, input logic [7:0] blk, input logic [7:0] page,
                           input logic illegal);
      int bad;
      chk("err", 32'(got_err), 32'(illegal));
      chk("ready_low_in_done", 32'(ready_at_done), 0);
      if (illegal) begin
         chk("illegal_latency", 32'(t_done), 1);
         chk("illegal_no_cmd", 32'(n_c01 + n_c10 + n_c11), 0);
         chk("illegal_no_wr", 32'(got_wr.size()), 0);
      end else if (op == OP_ERASE) begin
         chk("erase_cmd_cycles", 32'(n_c01), 1);
         for (int k = 0; k < PS; k++) ref_pg[blk][page][k] = 8'hFF;
      end else if (op == OP_PROGRAM) begin
         chk("prog_strobes", 32'(got_wr.size()), PS);
         bad = 0;
         for (int k = 0; k < PS && k < got_wr.size(); k++) if (got_wr[k] !== wbuf[k]) bad++;
         chk("prog_bytes_bad", 32'(bad), 0);
         chk("prog_no_rdata", 32'(n_rv), 0);
`ifdef NAND_CTRL_VERIFY_EN
         chk("prog_readback_cycles", 32'(n_c11), PS);
`else
         chk("prog_readback_cycles", 32'(n_c11), 0);
`endif
         for (int k = 0; k < PS; k++) ref_pg[blk][page][k] = wbuf[k];
      end else begin
         chk("read_cmd_cycles", 32'(n_c11), PS);
         chk("read_rv_count", 32'(n_rv), PS);
         chk("read_rv_start", 32'(t_rv_first), 32'(t_c11 + 1));
         chk("read_rv_contig", 32'(t_rv_last - t_rv_first + 1), PS);
         bad = 0;
         for (int k = 0; k < PS; k++)
            if (k >= got_rd.size() || got_rd[k] !== ref_pg[blk][page][k]) bad++;
         chk("read_bytes_bad", 32'(bad), 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int strobes;
      int idx;
      logic [1:0] op;
      logic [7:0] blk, page;
      logic illegal;

      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_blk = 8'h00; req_page = 8'h00;
      wdata_valid = 1'b0; wdata = 8'h00;
      force_busy = 1'b0; flip_arm = 1'b0; busy_len = 3; gap_pct = 0;
      for (int b = 0; b < NB; b++)
         for (int p = 0; p < NP; p++)
            for (int k = 0; k < PS; k++) ref_pg[b][p][k] = 8'((b*64 + p*16 + k)*7 + 3);

      vecs[0] = '{OP_ERASE,   8'd1, 8'd2, 0, 1'b0};
      vecs[1] = '{OP_READ,    8'd1, 8'd2, 0, 1'b0};
      vecs[2] = '{OP_PROGRAM, 8'd0, 8'd3, 0, 1'b0};
      vecs[3] = '{OP_READ,    8'd0, 8'd3, 0, 1'b0};
      vecs[4] = '{OP_ERASE,   8'd4, 8'd0, 0, 1'b1};
      vecs[5] = '{OP_IDLE,    8'd0, 8'd0, 0, 1'b1};
      vecs[6] = '{OP_READ,    8'd0, 8'd4, 0, 1'b1};
      vecs[7] = '{OP_PROGRAM, 8'd3, 8'd3, 1, 1'b0};
      vecs[8] = '{OP_READ,    8'd3, 8'd3, 0, 1'b0};
      vecs[9] = '{OP_PROGRAM, 8'hFF, 8'd0, 0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // table-driven requests
      for (int i = 0; i < NV; i++) begin
         busy_len = 4; gap_pct = 40;
         for (int k = 0; k < PS; k++) wbuf[k] = (vecs[i].pat == 0) ? 8'(k) : 8'($urandom);
         run_op(vecs[i].op, vecs[i].blk, vecs[i].page);
         check_op(vecs[i].op, vecs[i].blk, vecs[i].page, vecs[i].illegal);
      end

      // busy stuck high after ERASE
      force_busy = 1'b1; busy_len = 0;
      run_op(OP_ERASE, 8'd3, 8'd0);
      chk("timeout_err", 32'(got_err), 1);
      chk("timeout_latency", 32'(t_done), 32'(t_c01 + 1 + BT));
      force_busy = 1'b0;
      for (int k = 0; k < PS; k++) ref_pg[3][0][k] = 8'hFF;

      // reset after 5 PROGRAM strobes
      for (int k = 0; k < PS; k++) wbuf[k] = 8'(8'h30 + k);
      busy_len = 2;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = OP_PROGRAM; req_blk = 8'd2; req_page = 8'd1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      strobes = 0; idx = 0;
      for (int t = 0; t < 40 && strobes < 5; t++) begin
         if (f_wr_en) strobes++;
         if (strobes == 5) begin
            wdata_valid = 1'b0;
            rst_n = 1'b0;
         end else begin
            wdata_valid = 1'b1;
            wdata = wbuf[idx];
            if (wdata_ready) idx++;
            @(posedge clk); #1;
         end
      end
      chk("midprog_strobes", 32'(strobes), 5);
      @(posedge clk); #1;
      chk_reset("midprog_reset");
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) ref_pg[2][1][k] = wbuf[k];
      run_op(OP_READ, 8'd2, 8'd1);
      check_op(OP_READ, 8'd2, 8'd1, 1'b0);

`ifdef NAND_CTRL_VERIFY_EN
      // corrupted read-back byte 7
      for (int k = 0; k < PS; k++) wbuf[k] = 8'($urandom);
      flip_arm = 1'b1; gap_pct = 20;
      run_op(OP_PROGRAM, 8'd1, 8'd1);
      flip_arm = 1'b0;
      chk("verify_err", 32'(got_err), 1);
      chk("verify_no_rdata", 32'(n_rv), 0);
      chk("verify_strobes", 32'(got_wr.size()), PS);
      chk("verify_readback_cycles", 32'(n_c11), PS);
      for (int k = 0; k < PS; k++) ref_pg[1][1][k] = wbuf[k];
      run_op(OP_READ, 8'd1, 8'd1);
      check_op(OP_READ, 8'd1, 8'd1, 1'b0);
`endif

      // randomized requests against the reference
      for (int i = 0; i < 40; i++) begin
         op   = ($urandom_range(9) == 0) ? 2'b00 : 2'($urandom_range(3, 1));
         blk  = ($urandom_range(9) == 0) ? 8'(4 + $urandom_range(200)) : 8'($urandom_range(3));
         page = ($urandom_range(9) == 0) ? 8'(4 + $urandom_range(200)) : 8'($urandom_range(3));
         illegal = (op == 2'b00) || (blk >= 8'(NB)) || (page >= 8'(NP));
         busy_len = int'($urandom_range(12));
         gap_pct  = int'($urandom_range(60));
         for (int k = 0; k < PS; k++) wbuf[k] = 8'($urandom);
         run_op(op, blk, page);
         check_op(op, blk, page, illegal);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
